// File: rtl/pulse_period_meter.sv
// Measures period and high time of an asynchronous 1-bit signal in clk_50M cycles,
// with a one-cycle valid strobe per completed period and a sticky no-edge timeout.
module pulse_period_meter #(
    parameter int unsigned CNT_W   = 27,
    parameter int unsigned TIMEOUT = 100_000_000
) (
    input  logic             clk_50M,
    input  logic             rst_n,
    input  logic             sig_in_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_time_o,
    output logic             meas_valid_o,
    output logic             timeout_o,
    output logic             busy_o
);

    typedef enum logic [0:0] {StIdle, StMeasure} state_e;

    localparam logic [CNT_W-1:0] CntLimit = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    logic             rise, fall;
    logic [CNT_W-1:0] cnt_inc;

    assign rise    = s2_q & ~s3_q;
    assign fall    = ~s2_q & s3_q;
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_cap_q  <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            s1_q      <= sig_in_i;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_cap_q  <= hi_cap_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_cap_d  = hi_cap_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;

        // clr outranks any edge seen in the same cycle: no capture, no strobe
        if (clr_i) begin
            state_d   = StIdle;
            cnt_d     = '0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    cnt_d = '0;
                    if (rise) begin
                        state_d = StMeasure;
                    end
                end
                StMeasure: begin
                    cnt_d = cnt_inc;
                    if (fall) begin
                        hi_cap_d = cnt_inc;
                    end
                    // a rise on the limit cycle still reports rather than timing out
                    if (rise) begin
                        period_d  = cnt_inc;
                        high_d    = hi_cap_q;
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
                        cnt_d     = '0;
                    end else if (cnt_q == CntLimit) begin
                        timeout_d = 1'b1;
                        state_d   = StIdle;
                        cnt_d     = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign period_o     = period_q;
    assign high_time_o  = high_q;
    assign meas_valid_o = valid_q;
    assign timeout_o    = timeout_q;
    assign busy_o       = (state_q == StMeasure);

endmodule

// File: tb/tb_pulse_period_meter.sv
// Bench for pulse_period_meter: edge-timestamp reference model checked every cycle,
// plus literal checks for the directed scenarios.
module tb_pulse_period_meter;

    localparam int unsigned CNT_W = 27;
    localparam int unsigned TMO   = 1000;

    logic             clk_50M = 1'b0;
    logic             rst_n   = 1'b1;
    logic             sig_in  = 1'b0;
    logic             clr     = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             timeout;
    logic             busy;

    int checks = 0;
    int errors = 0;

    pulse_period_meter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TMO)
    ) dut (
        .clk_50M      (clk_50M),
        .rst_n        (rst_n),
        .sig_in_i     (sig_in),
        .clr_i        (clr),
        .period_o     (period),
        .high_time_o  (high_time),
        .meas_valid_o (meas_valid),
        .timeout_o    (timeout),
        .busy_o       (busy)
    );

    always #10 clk_50M = ~clk_50M;

    // Reference model: raw samples delayed by the synchroniser, then edges are
    // timestamped and results are differences of timestamps.
    logic             p1, p2, p3;
    int               mcyc;
    bit               armed;
    int               rise_at, fall_at;
    logic [CNT_W-1:0] e_period, e_high;
    bit               e_valid, e_tmo;

    always @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            p1 = 1'b0; p2 = 1'b0; p3 = 1'b0;
            armed = 1'b0; rise_at = 0; fall_at = 0;
            e_period = '0; e_high = '0; e_valid = 1'b0; e_tmo = 1'b0;
        end else begin
            bit rise, fall;
            mcyc++;
            rise = p2 & ~p3;
            fall = ~p2 & p3;
            e_valid = 1'b0;
            if (clr) begin
                armed = 1'b0;
                e_tmo = 1'b0;
            end else if (!armed) begin
                if (rise) begin
                    armed   = 1'b1;
                    rise_at = mcyc;
                end
            end else if (rise) begin
                e_period = CNT_W'(mcyc - rise_at);
                e_high   = CNT_W'(fall_at - rise_at);
                e_valid  = 1'b1;
                e_tmo    = 1'b0;
                rise_at  = mcyc;
            end else if (mcyc - rise_at == int'(TMO)) begin
                e_tmo = 1'b1;
                armed = 1'b0;
            end else if (fall) begin
                fall_at = mcyc;
            end
            p3 = p2; p2 = p1; p1 = sig_in;
        end
    end

    int ncyc = 0;
    int vcount = 0;
    int last_v_cyc = 0;
    int tmo_cyc = 0;
    bit tmo_prev = 1'b0;

    always @(posedge clk_50M) ncyc++;

    always @(negedge clk_50M) begin
        checks++;
        if ({busy, timeout, meas_valid, period, high_time} !==
            {armed, e_tmo, e_valid, e_period, e_high}) begin
            errors++;
            $display("FAIL cycle %0d outputs: got busy=%0b tmo=%0b valid=%0b period=%0d high=%0d, expected busy=%0b tmo=%0b valid=%0b period=%0d high=%0d",
                     ncyc, busy, timeout, meas_valid, period, high_time,
                     armed, e_tmo, e_valid, e_period, e_high);
        end
        if (meas_valid === 1'b1) begin
            vcount++;
            last_v_cyc = ncyc;
        end
        if (timeout === 1'b1 && !tmo_prev) tmo_cyc = ncyc;
        tmo_prev = (timeout === 1'b1);
    end

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_50M);
            #2;
        end
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        repeat (n) begin
            sig_in = 1'b1;
            step(hi);
            sig_in = 1'b0;
            step(lo);
        end
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
    endtask

    initial begin
        int v0;
        #1 rst_n = 1'b0;

        // Reset held with input toggling
        for (int i = 0; i < 200; i++) begin
            if (i % 7 == 0) sig_in = ~sig_in;
            step(1);
        end
        check("reset_outputs", {period, high_time, meas_valid, timeout, busy}, 0);
        sig_in = 1'b0;
        rst_n  = 1'b1;
        step(10);

        // 50/50 square wave, 5 periods
        v0 = vcount;
        wave(50, 50, 5);
        step(5);
        check("sq_valid_count", vcount - v0, 4);
        check("sq_period", period, 100);
        check("sq_high", high_time, 50);
        check("sq_busy", busy, 1);

        // Fastest input: 1 high / 1 low
        v0 = vcount;
        wave(1, 1, 20);
        step(5);
        check("fast_valid_count", vcount - v0, 20);
        check("fast_period", period, 2);
        check("fast_high", high_time, 1);

        // Timeout after 20/80 wave, then recovery with rises 300 apart
        clr_pulse();
        wave(20, 80, 3);
        step(1100);
        check("tmo_flag", timeout, 1);
        check("tmo_busy", busy, 0);
        check("tmo_period_held", period, 100);
        check("tmo_high_held", high_time, 20);
        check("tmo_latency", tmo_cyc - last_v_cyc, TMO);
        wave(30, 270, 1);
        sig_in = 1'b1;
        step(30);
        sig_in = 1'b0;
        step(10);
        check("rec_period", period, 300);
        check("rec_high", high_time, 30);
        check("rec_tmo_cleared", timeout, 0);

        // clr coincident with a detected rise
        clr_pulse();
        wave(50, 50, 2);
        v0 = vcount;
        sig_in = 1'b1;
        step(2);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check("clr_busy", busy, 0);
        step(47);
        sig_in = 1'b0;
        step(50);
        check("clr_no_valid", vcount - v0, 0);
        v0 = vcount;
        wave(50, 50, 2);
        step(5);
        check("clr_rearm_count", vcount - v0, 1);
        check("clr_rearm_period", period, 100);

        // Reset pulsed mid-period
        wave(50, 50, 1);
        sig_in = 1'b1;
        step(40);
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {period, high_time, meas_valid, timeout, busy}, 0);
        step(3);
        rst_n  = 1'b1;
        sig_in = 1'b0;
        step(60);
        v0 = vcount;
        wave(50, 50, 2);
        step(5);
        check("midrst_count", vcount - v0, 1);
        check("midrst_period", period, 100);
        check("midrst_high", high_time, 50);

        // Randomised traffic, including clr pulses and timeouts
        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 11);
            if (r == 0) begin
                clr_pulse();
            end else if (r == 1) begin
                sig_in = $urandom_range(0, 1);
                step($urandom_range(990, 1010));
            end else if (r == 2) begin
                sig_in = 1'b1;
                step($urandom_range(1, 3));
                clr = 1'b1;
                step(1);
                clr = 1'b0;
                sig_in = 1'b0;
                step($urandom_range(1, 10));
            end else begin
                wave($urandom_range(1, 40), $urandom_range(1, 40), $urandom_range(1, 3));
            end
        end
        step(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
